// File: rtl/modinv_pkg.sv
// Shared types for the modular inverse unit: FSM state encoding and the
// Bezout-coefficient width rule (operand width plus two sign/guard bits).
package modinv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    DIVIDE,
    UPDATE,
    FIX,
    DONE
  } modinv_state_t;

  localparam int T_EXTRA            = 2;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int T_WIDTH            = DEFAULT_DATA_WIDTH + T_EXTRA;

  function automatic int t_width(input int data_width);
    return data_width + T_EXTRA;
  endfunction

endpackage

// File: rtl/modular_inverse_divider.sv
// Restoring divider: one quotient bit per cycle, DATA_WIDTH cycles, one-cycle done pulse.
// The first bit is resolved on the start edge itself so results are ready DATA_WIDTH edges later.
module restoring_divider #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] quo_reg, rem_reg, div_reg;
  logic [DATA_WIDTH-1:0] src_quo, src_rem, src_div;
  logic [DATA_WIDTH-1:0] quo_next, rem_next;
  logic [DATA_WIDTH:0]   trial;
  logic                  trial_ge;
  logic [CW-1:0]         count_reg;
  logic                  done_reg;

  always_comb begin
    src_rem  = start ? '0 : rem_reg;
    src_quo  = start ? dividend : quo_reg;
    src_div  = start ? divisor : div_reg;
    trial    = {src_rem, src_quo[DATA_WIDTH-1]};
    trial_ge = (trial >= {1'b0, src_div});
    rem_next = trial_ge ? DATA_WIDTH'(trial - {1'b0, src_div}) : trial[DATA_WIDTH-1:0];
    quo_next = {src_quo[DATA_WIDTH-2:0], trial_ge};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      quo_reg   <= '0;
      rem_reg   <= '0;
      div_reg   <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else if (start) begin
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      div_reg   <= divisor;
      count_reg <= CW'(DATA_WIDTH - 1);
      done_reg  <= 1'b0;
    end else if (count_reg != '0) begin
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      count_reg <= count_reg - CW'(1);
      done_reg  <= (count_reg == CW'(1));
    end else begin
      done_reg  <= 1'b0;
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;
  assign done      = done_reg;

endmodule

// File: rtl/modular_inverse.sv
// Iterative extended-Euclid modular inverse with set/finished handshake.
// Define MODINV_GCD_EN to expose the final gcd on port gcd.
module modular_inverse
  import modinv_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] modulant,
  input  logic                  set,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  invertible,
  output logic                  finished
`ifdef MODINV_GCD_EN
  ,
  output logic [DATA_WIDTH-1:0] gcd
`endif
);

  localparam int TW = t_width(DATA_WIDTH);
  localparam int PW = 2 * DATA_WIDTH + 2;

  modinv_state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] r0_reg, r1_reg, q_reg, mod_reg;
  logic signed [TW-1:0]  t0_reg, t1_reg;
  logic [DATA_WIDTH-1:0] out_reg;
  logic                  invertible_reg, finished_reg;

  logic                  div_start, div_done;
  logic [DATA_WIDTH-1:0] div_quotient, div_remainder;
  logic                  start_ok;
  logic signed [PW-1:0]  qt_prod;
  logic signed [TW-1:0]  qt_trunc, t1_new, t0_adj;

  restoring_divider #(.DATA_WIDTH(DATA_WIDTH)) u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .dividend  (r0_reg),
    .divisor   (r1_reg),
    .quotient  (div_quotient),
    .remainder (div_remainder),
    .done      (div_done)
  );

  assign start_ok = (modulant >= DATA_WIDTH'(2)) && (a != '0);

  // Coefficients stay bounded by the modulus, so truncating the product is exact.
  assign qt_prod  = $signed({{(DATA_WIDTH + 2){1'b0}}, q_reg}) *
                    $signed({{DATA_WIDTH{t1_reg[TW-1]}}, t1_reg});
  assign qt_trunc = qt_prod[TW-1:0];
  assign t1_new   = t0_reg - qt_trunc;
  assign t0_adj   = t0_reg[TW-1] ? (t0_reg + $signed({2'b00, mod_reg})) : t0_reg;

  always_comb begin
    state_next = state_reg;
    div_start  = 1'b0;
    case (state_reg)
      IDLE:   state_next = IDLE;
      LAUNCH: begin
        div_start  = 1'b1;
        state_next = DIVIDE;
      end
      DIVIDE: if (div_done) state_next = UPDATE;
      UPDATE: state_next = (div_remainder == '0) ? FIX : LAUNCH;
      FIX:    state_next = DONE;
      DONE:   state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (set) begin
      state_next = start_ok ? LAUNCH : FIX;
      div_start  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      r0_reg         <= '0;
      r1_reg         <= '0;
      q_reg          <= '0;
      mod_reg        <= '0;
      t0_reg         <= '0;
      t1_reg         <= '0;
      out_reg        <= '0;
      invertible_reg <= 1'b0;
      finished_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (set) begin
        r0_reg         <= modulant;
        r1_reg         <= a;
        mod_reg        <= modulant;
        t0_reg         <= '0;
        t1_reg         <= TW'(1);
        out_reg        <= '0;
        invertible_reg <= 1'b0;
        finished_reg   <= 1'b0;
      end else begin
        case (state_reg)
          DIVIDE: if (div_done) q_reg <= div_quotient;
          UPDATE: begin
            r0_reg <= r1_reg;
            r1_reg <= div_remainder;
            t0_reg <= t1_reg;
            t1_reg <= t1_new;
          end
          FIX: begin
            if ((r0_reg == DATA_WIDTH'(1)) && (mod_reg >= DATA_WIDTH'(2))) begin
              invertible_reg <= 1'b1;
              out_reg        <= t0_adj[DATA_WIDTH-1:0];
            end else begin
              invertible_reg <= 1'b0;
              out_reg        <= '0;
            end
            finished_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MODINV_GCD_EN
  logic [DATA_WIDTH-1:0] gcd_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      gcd_reg <= '0;
    end else if (!set && state_reg == FIX) begin
      gcd_reg <= r0_reg;
    end
  end

  assign gcd = gcd_reg;
`endif

  assign out        = out_reg;
  assign invertible = invertible_reg;
  assign finished   = finished_reg;

endmodule

// File: tb/tb_modular_inverse.sv
// Scoreboard bench for modular_inverse: brute-force reference, latency and interrupt checks.
// Define MODINV_GCD_EN to also check the gcd port.
module tb_modular_inverse;

  localparam int W = 8;
  localparam int MAX_WAIT = 2000;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] modulant;
  logic         set;
  logic [W-1:0] out;
  logic         invertible;
  logic         finished;
`ifdef MODINV_GCD_EN
  logic [W-1:0] gcd;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int a;
    int m;
    int exp_out;
    int exp_inv;
    int exp_lat;
    int exp_gcd;
  } exp_t;

  exp_t sb[$];

  modular_inverse #(.DATA_WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .a          (a),
    .modulant   (modulant),
    .set        (set),
    .out        (out),
    .invertible (invertible),
    .finished   (finished)
`ifdef MODINV_GCD_EN
    ,
    .gcd        (gcd)
`endif
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input int av, input int mv);
    exp_t e;
    int x, y, r, k;
    e.a = av; e.m = mv; e.exp_out = 0; e.exp_inv = 0;
    if (mv >= 2 && av != 0) begin
      for (int i = 1; i < mv; i++) begin
        if ((av * i) % mv == 1) begin
          e.exp_out = i;
          e.exp_inv = 1;
          break;
        end
      end
      x = mv; y = av; k = 0;
      while (y != 0) begin
        r = x % y; x = y; y = r; k++;
      end
      e.exp_lat = k * (W + 2) + 1;
      e.exp_gcd = x;
    end else begin
      e.exp_lat = 1;
      e.exp_gcd = mv;
    end
    return e;
  endfunction

  task automatic pulse_set(input int av, input int mv);
    @(negedge clock);
    a = W'(av); modulant = W'(mv); set = 1'b1;
    @(posedge clock); #1;
    set = 1'b0;
  endtask

  task automatic wait_finished(output int n);
    n = 0;
    while (n < MAX_WAIT) begin
      @(posedge clock); #1;
      n++;
      if (finished) break;
    end
  endtask

  task automatic run_op(input int av, input int mv);
    exp_t e;
    int n;
    sb.push_back(model(av, mv));
    pulse_set(av, mv);
    checks++;
    if (finished !== 1'b0) begin
      errors++;
      $display("FAIL clear_on_set a=%0d m=%0d finished=%b required 0", av, mv, finished);
    end
    wait_finished(n);
    e = sb.pop_front();
    checks++;
    if (finished !== 1'b1 || n != e.exp_lat) begin
      errors++;
      $display("FAIL latency a=%0d m=%0d edges=%0d finished=%b required %0d", av, mv, n, finished, e.exp_lat);
    end
    checks++;
    if (out !== W'(e.exp_out) || invertible !== e.exp_inv[0]) begin
      errors++;
      $display("FAIL result a=%0d m=%0d out=%0d inv=%b required out=%0d inv=%0d", av, mv, out, invertible, e.exp_out, e.exp_inv);
    end
`ifdef MODINV_GCD_EN
    checks++;
    if (gcd !== W'(e.exp_gcd)) begin
      errors++;
      $display("FAIL gcd a=%0d m=%0d gcd=%0d required %0d", av, mv, gcd, e.exp_gcd);
    end
`endif
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (finished !== 1'b1 || out !== W'(e.exp_out) || invertible !== e.exp_inv[0]) begin
      errors++;
      $display("FAIL hold a=%0d m=%0d out=%0d inv=%b fin=%b required out=%0d inv=%0d fin=1", av, mv, out, invertible, finished, e.exp_out, e.exp_inv);
    end
    $display("op a=%0d m=%0d out=%0d inv=%b edges=%0d", av, mv, out, invertible, n);
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (out !== '0 || invertible !== 1'b0 || finished !== 1'b0) begin
      errors++;
      $display("FAIL %s out=%0d inv=%b fin=%b required all 0", name, out, invertible, finished);
    end
`ifdef MODINV_GCD_EN
    checks++;
    if (gcd !== '0) begin
      errors++;
      $display("FAIL %s_gcd gcd=%0d required 0", name, gcd);
    end
`endif
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (finished) seen = 1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s finished rose within %0d cycles, required stay 0", name, cycles);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; set = 1'b0; a = '0; modulant = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_cleared("reset_state");
    $display("reset state checked");
  endtask

  task automatic test_vectors;
    int av_tab[8] = '{3, 7, 4, 10, 233, 0, 5, 1};
    int mv_tab[8] = '{7, 40, 6, 7, 144, 5, 1, 2};
    for (int i = 0; i < 8; i++) run_op(av_tab[i], mv_tab[i]);
    for (int i = 0; i < 4; i++) run_op($urandom_range(255, 0), $urandom_range(255, 2));
  endtask

  task automatic test_set_hold;
    exp_t e;
    int n;
    sb.push_back(model(7, 40));
    @(negedge clock);
    a = W'(7); modulant = W'(40); set = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (finished !== 1'b0) begin
      errors++;
      $display("FAIL set_hold finished=%b while set held, required 0", finished);
    end
    set = 1'b0;
    wait_finished(n);
    e = sb.pop_front();
    checks++;
    if (n != e.exp_lat || out !== W'(e.exp_out)) begin
      errors++;
      $display("FAIL set_hold edges=%0d out=%0d required %0d out=%0d", n, out, e.exp_lat, e.exp_out);
    end
    $display("set_hold out=%0d edges=%0d", out, n);
  endtask

  task automatic test_abort;
    pulse_set(3, 7);
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (finished !== 1'b0) begin
      errors++;
      $display("FAIL abort_midrun finished=%b required 0", finished);
    end
    run_op(7, 40);
  endtask

  task automatic test_reset_mid;
    run_op(3, 7);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    check_cleared("reset_in_done");
    pulse_set(3, 7);
    repeat (4) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    check_cleared("reset_midrun");
    check_quiet("reset_midrun_idle", 40);
    @(negedge clock);
    a = W'(3); modulant = W'(7); set = 1'b1; reset = 1'b1;
    @(posedge clock); #1;
    set = 1'b0; reset = 1'b0;
    check_quiet("reset_beats_set", 30);
    $display("reset interrupts checked");
    run_op(10, 7);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_set_hold();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modular_inverse.md
# modular_inverse

- Iterative extended-Euclid unit computing `out = a^-1 mod modulant`, with a flag when no inverse exists (gcd ≠ 1).
- It is the key-side counterpart of the modular exponentiation datapath: it derives the private exponent d = e^-1 mod φ that the exponentiator consumes for decryption.
- It uses the same `set`/`finished` start-and-hold handshake as the exponentiator, so both can share one controller.

## Interface
- `DATA_WIDTH`, default 8: operand and result width, unsigned.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `a`  in  DATA_WIDTH: value to invert; may be ≥ `modulant`.
- `modulant`  in  DATA_WIDTH: modulus.
- `set`  in  1: start pulse; samples `a` and `modulant`.
- `out`  out  DATA_WIDTH: inverse in [0, modulant-1], or 0 when not invertible.
- `invertible`  out  1: valid while `finished`=1; high iff gcd(a, modulant)=1 and modulant ≥ 2.
- `finished`  out  1: level, high from result until the next `set` or `reset`.
- `gcd`  out  DATA_WIDTH: present only with MODINV_GCD_EN (see Configuration).

## Operation
- Registers:
  - r0, r1: DATA_WIDTH unsigned.
  - t0, t1: signed, DATA_WIDTH+2 bits.
  - q: DATA_WIDTH.
- Load on `set`: r0←modulant, r1←a, t0←0, t1←1, `finished`←0, `out`←0, `invertible`←0.
- FSM states:
  - IDLE: wait for `set`.
  - LAUNCH: start divider on (r0, r1).
  - DIVIDE: wait for divider `done`.
  - UPDATE: r0←r1, r1←rem, t0←t1, t1←t0 − q·t1.
  - FIX: compute the result.
  - DONE: hold outputs.
- Transitions:
  - `set` → LAUNCH if modulant ≥ 2 and a ≠ 0, else → FIX.
  - LAUNCH → DIVIDE.
  - DIVIDE → UPDATE on `done`.
  - UPDATE → FIX if the new r1 = 0, else → LAUNCH.
  - FIX → DONE.
  - DONE → LAUNCH/FIX only on `set`.
- q·t1 is formed at 2·DATA_WIDTH+2 signed width, then truncated to DATA_WIDTH+2; the true result is bounded by modulant.
- FIX:
  - If r0 = 1 and modulant ≥ 2: `invertible`←1 and `out`←(t0 < 0 ? t0 + modulant : t0).
  - Otherwise `invertible`←0 and `out`←0.
  - `finished`←1.
- a ≥ modulant needs no pre-reduction: the first division yields q=0 and swaps the operands.
- `set` while busy aborts the current computation and restarts with the new inputs; no partial result is ever shown.

## Timing
- Reset values: `out`=0, `invertible`=0, `finished`=0, `gcd`=0, state=IDLE.
- Reset mid-operation returns to IDLE at that edge and clears the divider.
- `reset` and `set` in the same cycle: reset wins.
- One Euclid step (LAUNCH + DATA_WIDTH divide cycles + UPDATE) takes DATA_WIDTH+2 cycles.
- With k divisions, `finished` rises k·(DATA_WIDTH+2)+1 edges after the `set` edge.
- Degenerate inputs (a=0 or modulant<2) go straight to FIX: `finished` rises 1 edge after `set`.
- Outputs change only at the FIX edge and are stable throughout DONE.
- `set` is a single-cycle pulse; holding it high keeps reloading, and the unit does not finish while it is held.

## Configuration
- Macro: MODINV_GCD_EN.
- Defined:
  - Adds port `gcd`, loaded with the final r0 at FIX.
  - For modulant < 2, `gcd` = modulant.
  - For a=0, `gcd` = modulant.
- Undefined: port and register are absent; all other behaviour is identical.

## Structure
- Shared package `modinv_pkg`:
  - state enum `modinv_state_t` (IDLE, LAUNCH, DIVIDE, UPDATE, FIX, DONE);
  - localparam `T_WIDTH` = DATA_WIDTH+2.
- Sub-module `restoring_divider`:
  - parameter DATA_WIDTH; ports `clock`, `reset`, `start`, dividend, divisor, quotient, remainder, `done`;
  - one quotient bit per cycle, DATA_WIDTH cycles;
  - `done` is a one-cycle pulse;
  - the divisor is guaranteed non-zero by the FSM.

## Test plan
- a=3, modulant=7 → `out`=5, `invertible`=1; `finished` at edge 21 after `set` (k=2).
- a=7, modulant=40 → `out`=23, `invertible`=1; `finished` at edge 41 (k=4).
- a=4, modulant=6 → `out`=0, `invertible`=0, `finished`=1; `gcd`=2 with MODINV_GCD_EN.
- a=10, modulant=7 (a > modulant) → `out`=5.
- a=233, modulant=144 (Fibonacci worst case) → `out`=89.
- a=0 or modulant=1 → `finished` 1 edge after `set`, `invertible`=0.
- Interrupts:
  - `set` for a=3, m=7 starts a run; `reset` 5 cycles later clears all outputs.
  - A fresh `set` (a=7, m=40) mid-run is honoured, giving `out`=23 at edge 41 after that `set`.
